// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing, data width and receiver state encoding.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DATA_BITS            = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_e;

   // High when the received parity bit does not make the frame even.
   function automatic logic even_parity_bad(input logic [DATA_BITS-1:0] data,
                                            input logic                 par_bit);
      return (^data) ^ par_bit;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for one asynchronous input; reset value is a parameter so
// idle-high and idle-low lines can both use it.
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1,
   parameter int   STAGES    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign sync_d[gi] = d;
         end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Bits are sampled mid-period off a single counter restarted at the validated start bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_data,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

   logic rx_s;

   uart_rx_sync #(
      .RESET_VAL (1'b1),
      .STAGES    (2)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_data),
      .q   (rx_s)
   );

   rx_state_e            state_q,     state_d;
   logic [CW-1:0]        cnt_q,       cnt_d;
   logic [2:0]           idx_q,       idx_d;
   logic [DATA_BITS-1:0] sh_q,        sh_d;
   logic [DATA_BITS-1:0] dout_q,      dout_d;
   logic                 rx_done_q,   rx_done_d;
   logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bad_q, parity_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      sh_d        = sh_q;
      dout_d      = dout_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_d = parity_bad_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               cnt_d   = '0;
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
               cnt_d = '0;
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               parity_bad_d = even_parity_bad(sh_q, rx_s);
               cnt_d        = '0;
               state_d      = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif

         ST_STOP: begin
            // Leaving here mid-stop-bit is what lets a back-to-back start edge be caught.
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (parity_bad_q) begin
                     parity_err_d = 1'b1;
                  end else begin
                     dout_d    = sh_q;
                     rx_done_d = 1'b1;
                  end
`else
                  dout_d    = sh_q;
                  rx_done_d = 1'b1;
`endif
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         dout_q      <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         dout_q      <= dout_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_bad_q <= parity_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign dout      = dout_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx (8N1 build): serial frames are generated from bytes, and the expected
// strobes, values and times come from the frame-level rules of the receiver.
module tb_uart_rx;

   localparam int CPB  = 87;
   localparam int HALF = CPB / 2;
   localparam int K_DONE = 0;
   localparam int K_FERR = 1;
   localparam int K_PERR = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_data = 1'b1;
   logic [7:0] dout;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .dout       (dout),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   typedef struct {
      int         kind;
      logic [7:0] data;
      longint     at;
   } ev_t;

   ev_t        got_q[$];
   ev_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         multi_strobe = 0;
   longint     cyc = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if ((int'(rx_done) + int'(frame_err) + int'(parity_err)) > 1) multi_strobe++;
      if (rx_done)    got_q.push_back('{K_DONE, dout, cyc});
      if (frame_err)  got_q.push_back('{K_FERR, dout, cyc});
      if (parity_err) got_q.push_back('{K_PERR, dout, cyc});
   end

   // Strobe lands on the stop sample: 2 sync cycles, 1 cycle for IDLE to react, half a bit, 9 bits.
   function automatic longint strobe_time(input longint t0);
      return t0 + 3 + HALF + 9 * CPB;
   endfunction

   // Called at a negedge; leaves the line at the stop-bit level when done.
   task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int period,
                              output longint t0);
      rx_data = 1'b0;
      t0 = cyc;
      repeat (period) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_data = b[i];
         repeat (period) @(negedge clk);
      end
      rx_data = stop_bit;
      repeat (period) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_dout: got 0x%02h expected 0x00", dout);
      end
      repeat (20000) @(negedge clk);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL reset_quiet: got %0d strobes expected 0", got_q.size());
      end
      checks++;
      if ({rx_done, frame_err, parity_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 000", {rx_done, frame_err, parity_err});
      end
      $display("reset: dout 0x%02h, %0d strobes", dout, got_q.size());
      got_q.delete();
   endtask

   task automatic test_single_byte();
      longint t0;
      drive_frame(8'hA5, 1'b1, CPB, t0);
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      last_good = 8'hA5;
      checks++;
      if (got_q.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d strobes expected 1", got_q.size());
      end else begin
         $display("single: kind %0d data 0x%02h at %0d", got_q[0].kind, got_q[0].data, got_q[0].at);
         checks++;
         if (got_q[0].kind != K_DONE || got_q[0].data !== 8'hA5) begin
            errors++;
            $display("FAIL single_value: got kind %0d 0x%02h expected kind %0d 0xa5",
                     got_q[0].kind, got_q[0].data, K_DONE);
         end
         checks++;
         if (got_q[0].at != strobe_time(t0)) begin
            errors++;
            $display("FAIL single_time: got %0d expected %0d", got_q[0].at, strobe_time(t0));
         end
      end
      checks++;
      if (dout !== 8'hA5) begin
         errors++;
         $display("FAIL single_hold: got 0x%02h expected 0xa5", dout);
      end
      got_q.delete();
   endtask

   task automatic test_glitch();
      longint t0;
      rx_data = 1'b0;
      repeat (20) @(negedge clk);
      rx_data = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_quiet: got %0d strobes expected 0", got_q.size());
      end
      drive_frame(8'h3C, 1'b1, CPB, t0);
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      last_good = 8'h3C;
      checks++;
      if (got_q.size() != 1 || got_q[0].kind != K_DONE || got_q[0].data !== 8'h3C
          || got_q[0].at != strobe_time(t0)) begin
         errors++;
         $display("FAIL glitch_next: got %0d strobes (first 0x%02h) expected one 0x3c at %0d",
                  got_q.size(), got_q.size() > 0 ? got_q[0].data : 8'h00, strobe_time(t0));
      end else begin
         $display("glitch: rejected, then 0x%02h at %0d", got_q[0].data, got_q[0].at);
      end
      got_q.delete();
   endtask

   task automatic test_frame_err();
      longint t0;
      drive_frame(8'h55, 1'b0, CPB, t0);
      repeat (2000) @(negedge clk);
      rx_data = 1'b1;
      repeat (CPB) @(negedge clk);
      checks++;
      if (got_q.size() != 1 || got_q[0].kind != K_FERR || got_q[0].at != strobe_time(t0)) begin
         errors++;
         $display("FAIL ferr_strobe: got %0d strobes (kind %0d) expected one frame_err at %0d",
                  got_q.size(), got_q.size() > 0 ? got_q[0].kind : -1, strobe_time(t0));
      end else begin
         $display("frame_err: at %0d", got_q[0].at);
      end
      checks++;
      if (dout !== last_good) begin
         errors++;
         $display("FAIL ferr_dout: got 0x%02h expected 0x%02h", dout, last_good);
      end
      got_q.delete();
      drive_frame(8'h81, 1'b1, CPB, t0);
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      last_good = 8'h81;
      checks++;
      if (got_q.size() != 1 || got_q[0].kind != K_DONE || got_q[0].data !== 8'h81) begin
         errors++;
         $display("FAIL ferr_next: got %0d strobes (first 0x%02h) expected one 0x81",
                  got_q.size(), got_q.size() > 0 ? got_q[0].data : 8'h00);
      end else begin
         $display("after frame_err: 0x%02h", got_q[0].data);
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      longint     t0 [3];
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      bytes[2] = 8'h7E;
      for (int i = 0; i < 3; i++) drive_frame(bytes[i], 1'b1, CPB, t0[i]);
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      last_good = 8'h7E;
      checks++;
      if (got_q.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d strobes expected 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            $display("b2b: 0x%02h at %0d", got_q[i].data, got_q[i].at);
            checks++;
            if (got_q[i].kind != K_DONE || got_q[i].data !== bytes[i]) begin
               errors++;
               $display("FAIL b2b_value[%0d]: got kind %0d 0x%02h expected 0x%02h",
                        i, got_q[i].kind, got_q[i].data, bytes[i]);
            end
            checks++;
            if (got_q[i].at != strobe_time(t0[0]) + longint'(i * 10 * CPB)) begin
               errors++;
               $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, got_q[i].at,
                        strobe_time(t0[0]) + longint'(i * 10 * CPB));
            end
         end
      end
      got_q.delete();
   endtask

   task automatic test_midframe_reset();
      rx_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_data = i[0];
         repeat (CPB) @(negedge clk);
      end
      rst = 1'b1;
      rx_data = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      last_good = 8'h00;
      checks++;
      if (dout !== 8'h00 || got_q.size() != 0) begin
         errors++;
         $display("FAIL midframe_reset: got dout 0x%02h, %0d strobes expected 0x00, 0", dout,
                  got_q.size());
      end else begin
         $display("midframe reset: dout 0x%02h, no strobe", dout);
      end
      got_q.delete();
   endtask

   task automatic test_random();
      int      nmatch;
      int      period [$];
      longint  t0;
      for (int n = 0; n < 10; n++) begin
         logic [7:0] b;
         logic       stop_bit;
         int         p;
         b = 8'($urandom);
         stop_bit = ($urandom_range(0, 4) != 0);
         p = CPB - 2 + int'($urandom_range(0, 4));
         drive_frame(b, stop_bit, p, t0);
         period.push_back(p);
         if (stop_bit) begin
            exp_q.push_back('{K_DONE, b, strobe_time(t0)});
            last_good = b;
            rx_data = 1'b1;
            repeat ($urandom_range(0, 30)) @(negedge clk);
         end else begin
            exp_q.push_back('{K_FERR, 8'h00, strobe_time(t0)});
            repeat ($urandom_range(0, 200)) @(negedge clk);
            rx_data = 1'b1;
            repeat ($urandom_range(4, 30)) @(negedge clk);
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d strobes expected %0d", got_q.size(), exp_q.size());
      end
      nmatch = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmatch; i++) begin
         $display("rand[%0d]: period %0d kind %0d data 0x%02h at %0d", i, period[i],
                  got_q[i].kind, got_q[i].data, got_q[i].at);
         checks++;
         if (got_q[i].kind != exp_q[i].kind
             || (exp_q[i].kind == K_DONE && got_q[i].data !== exp_q[i].data)) begin
            errors++;
            $display("FAIL rand_value[%0d]: got kind %0d 0x%02h expected kind %0d 0x%02h", i,
                     got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
         end
         if (period[i] == CPB) begin
            checks++;
            if (got_q[i].at != exp_q[i].at) begin
               errors++;
               $display("FAIL rand_time[%0d]: got %0d expected %0d", i, got_q[i].at,
                        exp_q[i].at);
            end
         end
      end
      checks++;
      if (dout !== last_good) begin
         errors++;
         $display("FAIL rand_dout: got 0x%02h expected 0x%02h", dout, last_good);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_exclusive();
      checks++;
      if (multi_strobe != 0) begin
         errors++;
         $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", multi_strobe);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_midframe_reset();
      test_random();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
